mc_datapath: RTL and testbench
==============================

MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter: XLEN, 32, data/address width. Legal values: 32 and 64. Instruction width is fixed at 32.
REQ-002 Parameter: RESET_PC, 0, PC value loaded by reset.
REQ-003 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Ports: ResultSrc in 2; PCSrc in 1; ALUSrc in 1; RegWrite in 1; ImmSrc in 2; ALUControl in 4; jalr in 1; MemAccess in 1; MemWrite in 1. These are decoded controls from the external decoder; they are sampled only in the states stated below.
REQ-006 Port: Instr  out  32  instruction register.
REQ-007 Port: PC  out  XLEN  program-counter register.
REQ-008 Ports: Zero, less_than, unsigned_less_than  out  1 each  ALU flags from the current operands.
REQ-009 Ports: mem_req out 1; mem_we out 1; mem_addr out XLEN; mem_wdata out XLEN; mem_rdata in XLEN; mem_ready in 1. Unified instruction/data memory handshake.
REQ-010 Ports: Result out XLEN (writeback value); instr_done out 1 (one-cycle retire pulse).

Function
REQ-011 States: FETCH, EXECUTE, MEM, WB.
REQ-012 FETCH:
- Outputs: mem_req=1, mem_we=0, mem_addr=PC.
- When mem_ready=1: Instr<=mem_rdata[31:0], move to EXECUTE.
- Otherwise stay in FETCH.
REQ-013 EXECUTE:
- ALU SrcA = rs1. SrcB = rs2 when ALUSrc=0, else the immediate from ImmSrc (I/S/B/J encodings).
- On exit: ALUOut<=ALU result, WData<=rs2.
- Next state: MEM if MemAccess=1, otherwise WB.
REQ-014 MEM:
- Outputs: mem_req=1, mem_we=MemWrite, mem_addr=ALUOut, mem_wdata=WData.
- When mem_ready=1: RData<=mem_rdata, move to WB.
- Otherwise hold all outputs stable and stay in MEM.
REQ-015 WB, Result selection by ResultSrc:
- 0 = ALUOut.
- 1 = RData.
- 2 = PC+4.
- 3 = LUI/AUIPC value: imm = sign-extended {Instr[31:12],12'b0}; use PC+imm when Instr[5]=0, imm when Instr[5]=1.
REQ-016 WB, register write:
- When RegWrite=1 and rd≠0, write Result into rd.
- x0 always reads 0.
REQ-017 WB, PC update:
- jalr=1: PC <= ALUOut with bit0 cleared.
- else PCSrc=1: PC <= PC + imm.
- else: PC <= PC+4.
- PC arithmetic wraps modulo 2^XLEN.
REQ-018 WB also asserts instr_done=1 for exactly one cycle and moves to FETCH.
REQ-019 The register file has 32 entries of XLEN bits, 2 async read ports and 1 sync write port. A write in WB is visible to the following EXECUTE.
REQ-020 mem_req=0, mem_we=0 and instr_done=0 in EXECUTE; mem_req=0 and mem_we=0 in WB.
REQ-021 mem_ready is ignored outside FETCH/MEM. A mem_ready arriving in the same cycle as mem_req rises completes that access (zero-wait memory). Fetch-to-retire therefore takes 3 cycles for non-memory and 4 cycles for memory instructions.
REQ-022 mem_rdata is captured only in the cycle where mem_ready=1 and the state is FETCH or MEM.
REQ-023 When XLEN=64, addresses and immediates are sign-extended to XLEN, and Instr takes mem_rdata[31:0].

Reset
REQ-024 While reset=1 at a clock edge:
- state<=FETCH, PC<=RESET_PC.
- Instr, ALUOut, WData and RData are cleared to 0.
- instr_done=0, mem_req=0, mem_we=0 during the reset cycle.
REQ-025 Reset overrides every state, including a pending MEM store. No register-file write and no memory write may complete in a reset cycle.
REQ-026 Register-file contents are not reset.
REQ-027 On the first cycle after reset deasserts: mem_req=1 and mem_addr=RESET_PC.

Verification
REQ-028 Reset: RESET_PC=0x100, reset 2 cycles -> PC=0x100, mem_req=1, mem_addr=0x100, instr_done=0.
REQ-029 ADDI x1,x0,5 with zero-wait memory:
- instr_done pulses on cycle 3.
- x1=5, Result=5, PC=0x104.
REQ-030 Fetch stall: mem_ready held 0 for 3 cycles -> state stays FETCH, mem_addr stable, no retire. Retire occurs 3 cycles later than the zero-wait case.
REQ-031 Load/store (x2=0x200):
- SW x1,8(x2) -> mem_we=1, mem_addr=0x208, mem_wdata=5.
- Following LW x3,8(x2) with memory returning 5 -> x3=5, 4-cycle retire.
REQ-032 Control flow:
- BEQ taken (PCSrc=1, imm=-8) at PC=0x110 -> PC=0x108.
- JALR (x1=0x301, imm=0) -> PC=0x300, rd=old PC+4.
REQ-033 Reset asserted in MEM with mem_we=1 and mem_ready=1 -> memory write is not performed, PC=RESET_PC, state FETCH next cycle.
REQ-034 XLEN=64 build: LUI imm 0x80000 -> rd=0xFFFFFFFF80000000.

Source files
------------

// File: rtl/mc_datapath.sv
// Multicycle RV-style datapath: FETCH -> EXECUTE -> (MEM) -> WB over a unified memory port.
// Controls come from an external decoder; this block owns PC, Instr, ALU, register file and sequencing.
module mc_datapath #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ResultSrc,
  input  logic            PCSrc,
  input  logic            ALUSrc,
  input  logic            RegWrite,
  input  logic [1:0]      ImmSrc,
  input  logic [3:0]      ALUControl,
  input  logic            jalr,
  input  logic            MemAccess,
  input  logic            MemWrite,
  output logic [31:0]     Instr,
  output logic [XLEN-1:0] PC,
  output logic            Zero,
  output logic            less_than,
  output logic            unsigned_less_than,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] Result,
  output logic            instr_done
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] EXECUTE = 2'd1;
  localparam logic [1:0] MEM     = 2'd2;
  localparam logic [1:0] WB      = 2'd3;
  localparam int         SH      = (XLEN == 64) ? 6 : 5;

  logic [1:0]      state;
  logic [XLEN-1:0] alu_out, wdata, rdata;
  logic [XLEN-1:0] rf [32];
  logic [4:0]      rs1_a, rs2_a, rd_a;
  logic [XLEN-1:0] rs1, rs2, imm, src_b, alu_y, u_imm, pc_plus4;

  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] imm_dec(input logic [31:0] ins, input logic [1:0] sel);
    logic [31:0] v;
    case (sel)
      2'b00:   v = {{20{ins[31]}}, ins[31:20]};
      2'b01:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      2'b10:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      default: v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endcase
    return sext32(v);
  endfunction

  assign rs1_a    = Instr[19:15];
  assign rs2_a    = Instr[24:20];
  assign rd_a     = Instr[11:7];
  assign rs1      = (rs1_a == 5'd0) ? '0 : rf[rs1_a];
  assign rs2      = (rs2_a == 5'd0) ? '0 : rf[rs2_a];
  assign imm      = imm_dec(Instr, ImmSrc);
  assign src_b    = ALUSrc ? imm : rs2;
  assign u_imm    = sext32({Instr[31:12], 12'b0});
  assign pc_plus4 = PC + XLEN'(4);

  assign less_than          = $signed(rs1) < $signed(src_b);
  assign unsigned_less_than = rs1 < src_b;

  always_comb begin
    alu_y = '0;
    case (ALUControl)
      4'd0:    alu_y = rs1 + src_b;
      4'd1:    alu_y = rs1 - src_b;
      4'd2:    alu_y = rs1 & src_b;
      4'd3:    alu_y = rs1 | src_b;
      4'd4:    alu_y = rs1 ^ src_b;
      4'd5:    alu_y = {{(XLEN-1){1'b0}}, less_than};
      4'd6:    alu_y = {{(XLEN-1){1'b0}}, unsigned_less_than};
      4'd7:    alu_y = rs1 << src_b[SH-1:0];
      4'd8:    alu_y = rs1 >> src_b[SH-1:0];
      4'd9:    alu_y = $signed(rs1) >>> src_b[SH-1:0];
      default: alu_y = '0;
    endcase
  end

  assign Zero = (alu_y == '0);

  always_comb begin
    Result = alu_out;
    case (ResultSrc)
      2'd0:    Result = alu_out;
      2'd1:    Result = rdata;
      2'd2:    Result = pc_plus4;
      default: Result = Instr[5] ? u_imm : PC + u_imm;
    endcase
  end

  // Memory strobes are suppressed during reset so a pending store cannot land.
  assign mem_req    = !reset && ((state == FETCH) || (state == MEM));
  assign mem_we     = !reset && (state == MEM) && MemWrite;
  assign mem_addr   = (state == MEM) ? alu_out : PC;
  assign mem_wdata  = wdata;
  assign instr_done = !reset && (state == WB);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      PC      <= RESET_PC;
      Instr   <= '0;
      alu_out <= '0;
      wdata   <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        // FETCH -> EXECUTE
        FETCH: if (mem_ready) begin
          Instr <= mem_rdata[31:0];
          state <= EXECUTE;
        end
        // EXECUTE -> MEM / WB
        EXECUTE: begin
          alu_out <= alu_y;
          wdata   <= rs2;
          state   <= MemAccess ? MEM : WB;
        end
        // MEM -> WB
        MEM: if (mem_ready) begin
          rdata <= mem_rdata;
          state <= WB;
        end
        // WB -> FETCH
        default: begin
          if (jalr)       PC <= {alu_out[XLEN-1:1], 1'b0};
          else if (PCSrc) PC <= PC + imm;
          else            PC <= pc_plus4;
          state <= FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (state == WB) && RegWrite && (rd_a != 5'd0))
      rf[rd_a] <= Result;
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: 32-bit instance against a small word memory, plus a 64-bit LUI build.
module tb_mc_datapath;

  logic        clk = 0;
  logic        reset;
  logic [1:0]  ResultSrc, ImmSrc;
  logic        PCSrc, ALUSrc, RegWrite, jalr, MemAccess, MemWrite;
  logic [3:0]  ALUControl;
  logic [31:0] Instr, PC, mem_addr, mem_wdata, mem_rdata, Result;
  logic        Zero, less_than, unsigned_less_than, mem_req, mem_we, mem_ready, instr_done;

  logic        reset64;
  logic [31:0] Instr64;
  logic [63:0] PC64, mem_addr64, mem_wdata64, Result64;
  logic        Zero64, lt64, ult64, mem_req64, mem_we64, instr_done64;

  logic [31:0] mem [1024];
  int          n_vec = 0, n_miss = 0, n_wr = 0;
  logic        st_seen;
  logic [31:0] st_addr, st_data;

  always #5 clk = ~clk;

  mc_datapath #(.XLEN(32), .RESET_PC(32'h100)) u_dut (
    .clk(clk), .reset(reset), .ResultSrc(ResultSrc), .PCSrc(PCSrc), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .jalr(jalr),
    .MemAccess(MemAccess), .MemWrite(MemWrite), .Instr(Instr), .PC(PC), .Zero(Zero),
    .less_than(less_than), .unsigned_less_than(unsigned_less_than), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .Result(Result), .instr_done(instr_done)
  );

  mc_datapath #(.XLEN(64), .RESET_PC(64'h0)) u_dut64 (
    .clk(clk), .reset(reset64), .ResultSrc(2'd3), .PCSrc(1'b0), .ALUSrc(1'b0),
    .RegWrite(1'b1), .ImmSrc(2'd0), .ALUControl(4'd0), .jalr(1'b0),
    .MemAccess(1'b0), .MemWrite(1'b0), .Instr(Instr64), .PC(PC64), .Zero(Zero64),
    .less_than(lt64), .unsigned_less_than(ult64), .mem_req(mem_req64),
    .mem_we(mem_we64), .mem_addr(mem_addr64), .mem_wdata(mem_wdata64),
    .mem_rdata(64'hDEADBEEF_800002B7), .mem_ready(1'b1), .Result(Result64),
    .instr_done(instr_done64)
  );

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr[11:2]] <= mem_wdata;
      n_wr <= n_wr + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic set_ctl(input logic [1:0] rs, input logic pcs, input logic as, input logic rw,
                         input logic [1:0] is, input logic [3:0] ac, input logic jr,
                         input logic ma, input logic mw);
    ResultSrc = rs; PCSrc = pcs; ALUSrc = as; RegWrite = rw; ImmSrc = is;
    ALUControl = ac; jalr = jr; MemAccess = ma; MemWrite = mw;
  endtask

  // Called in the FETCH cycle (#1 after an edge); returns on the next instruction's FETCH cycle.
  task automatic run_instr(output int cyc, output logic [31:0] res);
    cyc = 0;
    res = '0;
    for (int i = 1; i <= 20 && cyc == 0; i++) begin
      if (mem_req && mem_we) begin
        st_seen = 1'b1; st_addr = mem_addr; st_data = mem_wdata;
      end
      if (instr_done) begin
        cyc = i; res = Result;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  int          cyc, wr_before;
  logic [31:0] res;

  initial begin
    reset = 1; reset64 = 1; mem_ready = 1; st_seen = 0;
    set_ctl(2'd0, 0, 0, 0, 2'd0, 4'd0, 0, 0, 0);

    // reset
    @(posedge clk); #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_done", instr_done, 0);
    @(posedge clk); #1;
    reset = 0; #1;
    chk("rst_pc", PC, 32'h100);
    chk("rst_req_after", mem_req, 1);
    chk("rst_addr_after", mem_addr, 32'h100);
    chk("rst_done_after", instr_done, 0);

    // ADDI x1,x0,5
    mem[32'h100 >> 2] = 32'h00500093;
    set_ctl(2'd0, 0, 1, 1, 2'd0, 4'd0, 0, 0, 0);
    run_instr(cyc, res);
    chk("addi_cycles", cyc, 3);
    chk("addi_result", res, 5);
    chk("addi_x1", u_dut.rf[1], 5);
    chk("addi_pc", PC, 32'h104);

    // ADDI x2,x0,0x200 with 3-cycle fetch stall
    mem[32'h104 >> 2] = 32'h20000113;
    mem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_addr", mem_addr, 32'h104);
      chk("stall_done", instr_done, 0);
      @(posedge clk); #1;
    end
    chk("stall_instr_held", Instr, 32'h00500093);
    mem_ready = 1;
    run_instr(cyc, res);
    chk("stall_retire", 3 + cyc, 6);
    chk("stall_x2", u_dut.rf[2], 32'h200);
    chk("stall_pc", PC, 32'h108);

    // SW x1,8(x2)
    mem[32'h108 >> 2] = 32'h00112423;
    set_ctl(2'd0, 0, 1, 0, 2'd1, 4'd0, 0, 1, 1);
    st_seen = 0;
    run_instr(cyc, res);
    chk("sw_cycles", cyc, 4);
    chk("sw_we_seen", st_seen, 1);
    chk("sw_addr", st_addr, 32'h208);
    chk("sw_wdata", st_data, 5);
    chk("sw_mem", mem[32'h208 >> 2], 5);
    chk("sw_pc", PC, 32'h10C);

    // LW x3,8(x2)
    mem[32'h10C >> 2] = 32'h00812183;
    set_ctl(2'd1, 0, 1, 1, 2'd0, 4'd0, 0, 1, 0);
    run_instr(cyc, res);
    chk("lw_cycles", cyc, 4);
    chk("lw_result", res, 5);
    chk("lw_x3", u_dut.rf[3], 5);
    chk("lw_pc", PC, 32'h110);

    // BEQ x0,x0,-8 taken
    mem[32'h110 >> 2] = 32'hFE000CE3;
    set_ctl(2'd0, 1, 0, 0, 2'd2, 4'd1, 0, 0, 0);
    run_instr(cyc, res);
    chk("beq_cycles", cyc, 3);
    chk("beq_pc", PC, 32'h108);
    chk("beq_zero", Zero, 1);
    chk("beq_lt", less_than, 0);

    // ADDI x1,x0,0x301 then JALR x4,0(x1)
    mem[32'h108 >> 2] = 32'h30100093;
    set_ctl(2'd0, 0, 1, 1, 2'd0, 4'd0, 0, 0, 0);
    run_instr(cyc, res);
    chk("addi2_x1", u_dut.rf[1], 32'h301);
    mem[32'h10C >> 2] = 32'h00008267;
    set_ctl(2'd2, 0, 1, 1, 2'd0, 4'd0, 1, 0, 0);
    run_instr(cyc, res);
    chk("jalr_pc", PC, 32'h300);
    chk("jalr_link", u_dut.rf[4], 32'h110);

    // LUI x5,0x80000 ; AUIPC x6,1
    mem[32'h300 >> 2] = 32'h800002B7;
    set_ctl(2'd3, 0, 0, 1, 2'd0, 4'd0, 0, 0, 0);
    run_instr(cyc, res);
    chk("lui_x5", u_dut.rf[5], 32'h80000000);
    mem[32'h304 >> 2] = 32'h00001317;
    run_instr(cyc, res);
    chk("auipc_x6", u_dut.rf[6], 32'h1304);
    chk("auipc_pc", PC, 32'h308);

    // reset during a MEM-state store: SW x1,8(x2) would write 0x301
    mem[32'h308 >> 2] = 32'h00112423;
    set_ctl(2'd0, 0, 1, 0, 2'd1, 4'd0, 0, 1, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstmem_we_before", mem_we, 1);
    wr_before = n_wr;
    reset = 1; #1;
    chk("rstmem_we_gated", mem_we, 0);
    @(posedge clk); #1;
    reset = 0; #1;
    chk("rstmem_no_write", n_wr, wr_before);
    chk("rstmem_mem", mem[32'h208 >> 2], 5);
    chk("rstmem_pc", PC, 32'h100);
    chk("rstmem_req", mem_req, 1);
    chk("rstmem_addr", mem_addr, 32'h100);
    chk("rf_kept", u_dut.rf[1], 32'h301);

    // XLEN=64 LUI x5,0x80000
    reset64 = 0;
    cyc = 0;
    for (int i = 1; i <= 10 && cyc == 0; i++) begin
      if (instr_done64) begin
        cyc = i;
        chk("x64_result", Result64, 64'hFFFFFFFF80000000);
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("x64_cycles", cyc, 3);
    @(posedge clk); #1;
    chk("x64_x5", u_dut64.rf[5], 64'hFFFFFFFF80000000);
    chk("x64_pc", PC64, 64'h4);
    chk("x64_instr", Instr64, 32'h800002B7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
